// File: rtl/inv_mix_columns_iter.sv
// Iterative AES-128 InvMixColumns unit.
// Accepts one 128-bit state over a valid/ready handshake and transforms
// COLS_PER_CYCLE columns per clock with the GF(2^8) inverse column matrix.
// The finished state is held on data_out until the downstream stage takes it.
// Column c of a state sits at bits [127-32c -: 32]; row 0 is the top byte.

module inv_mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);

   // Compute cycles per block; the fallback of 1 only keeps elaboration
   // arithmetic sane while the error below reports the illegal value.
   localparam int NUM_STEPS = (COLS_PER_CYCLE == 1) ? 4 :
                              (COLS_PER_CYCLE == 2) ? 2 : 1;
   localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   // Only 1, 2 or 4 columns per cycle divide the four-column state evenly.
   generate
      if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : gBadColsPerCycle
         $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [STEP_W-1:0]   stepCnt_q;
   logic [127:0]        work_q;
   logic [127:0]        work_d;
   logic [127:0]        dataOut_q;
   logic                inReady_q;
   logic                outValid_q;
   logic                busy_q;

   // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Inverse column mix. The four coefficients 09/0b/0d/0e are all built
   // from the same x, x^2, x^3 chain of each byte, so each byte is
   // expanded once and the products are formed by XOR only.
   function automatic logic [31:0] invMixColumn(input logic [31:0] col);
      logic [7:0] a   [4];
      logic [7:0] x2  [4];
      logic [7:0] x4  [4];
      logic [7:0] x8  [4];
      logic [7:0] m09 [4];
      logic [7:0] m0b [4];
      logic [7:0] m0d [4];
      logic [7:0] m0e [4];
      for (int i = 0; i < 4; i++) begin
         a[i]   = col[31-8*i -: 8];
         x2[i]  = xtime(a[i]);
         x4[i]  = xtime(x2[i]);
         x8[i]  = xtime(x4[i]);
         m09[i] = x8[i] ^ a[i];
         m0b[i] = x8[i] ^ x2[i] ^ a[i];
         m0d[i] = x8[i] ^ x4[i] ^ a[i];
         m0e[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      invMixColumn[31:24] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
      invMixColumn[23:16] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
      invMixColumn[15:8]  = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
      invMixColumn[7:0]   = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];
   endfunction

   // Working state with the columns belonging to the current step transformed;
   // all other columns pass through untouched.
   always_comb begin
      work_d = work_q;
      for (int c = 0; c < 4; c++) begin
         if ((c / COLS_PER_CYCLE) == int'(stepCnt_q)) begin
            work_d[127-32*c -: 32] = invMixColumn(work_q[127-32*c -: 32]);
         end
      end
   end

   // Control FSM with registered handshake outputs; reset drops any partial block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         stepCnt_q  <= '0;
         work_q     <= '0;
         dataOut_q  <= '0;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && inReady_q) begin
                  work_q    <= data_in;
                  stepCnt_q <= '0;
                  inReady_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               work_q <= work_d;
               if (stepCnt_q == LAST_STEP) begin
                  dataOut_q  <= work_d;
                  outValid_q <= 1'b1;
                  busy_q     <= 1'b0;
                  stepCnt_q  <= '0;
                  state_q    <= DONE;
               end else begin
                  stepCnt_q <= stepCnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               stepCnt_q  <= '0;
               inReady_q  <= 1'b1;
               outValid_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign data_out  = dataOut_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Testbench for inv_mix_columns_iter: one instance per legal COLS_PER_CYCLE
// (1, 2, 4), checked against a matrix-level GF(2^8) reference model.

module tb_inv_mix_columns_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         inValid  [3];
   logic [127:0] dataIn   [3];
   logic         outReady [3];
   logic         inReady  [3];
   logic         outValid [3];
   logic         busy     [3];
   logic [127:0] dataOut  [3];

   int vectors     = 0;
   int miscompares = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Instance g runs with 2^g columns per cycle.
   generate
      for (genvar g = 0; g < 3; g++) begin : gDut
         inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (inValid[g]),
            .in_ready  (inReady[g]),
            .data_in   (dataIn[g]),
            .out_valid (outValid[g]),
            .out_ready (outReady[g]),
            .data_out  (dataOut[g]),
            .busy      (busy[g])
         );
      end
   endgenerate

   // General GF(2^8) multiply by shift-and-add.
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Column mix as a circulant matrix product; inverse selects the decrypt matrix.
   function automatic logic [127:0] refMix(input logic [127:0] s, input bit inverse);
      logic [7:0]   coef [4];
      logic [7:0]   a    [4];
      logic [7:0]   r;
      logic [127:0] res;
      res = '0;
      if (inverse) begin
         coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      end else begin
         coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
         for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r = r ^ gfMul(coef[(j - i + 4) % 4], a[j]);
            res[127-32*c-8*i -: 8] = r;
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] randState();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Single comparison point: counts the vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Hands one state to instance g (called at a negedge) and waits for its
   // result, scrambling data_in/in_valid while the block is busy. Returns at
   // the negedge where out_valid is first seen.
   task automatic applyStimulus(input int g, input logic [127:0] data);
      int           k;
      int           busyCnt;
      int           readyCnt;
      logic [127:0] expected;
      expected = refMix(data, 1'b1);
      k = 0;
      while (!inReady[g] && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput("in_ready_wait", 128'(inReady[g]), 128'(1));
      inValid[g] = 1'b1;
      dataIn[g]  = data;
      @(negedge clk);
      k        = 0;
      busyCnt  = 0;
      readyCnt = 0;
      while (!outValid[g] && k < 20) begin
         if (busy[g])    busyCnt++;
         if (inReady[g]) readyCnt++;
         inValid[g] = 1'($urandom);
         dataIn[g]  = randState();
         @(negedge clk);
         k++;
      end
      inValid[g] = 1'b0;
      checkOutput("latency", 128'(k), 128'(4 >> g));
      checkOutput("busy_cycles", 128'(busyCnt), 128'(4 >> g));
      checkOutput("in_ready_low_busy", 128'(readyCnt), 128'(0));
      checkOutput("result", dataOut[g], expected);
   endtask

   // Random states through the forward mixer then the DUT, with in_valid held
   // high back to back and random out_ready; output must equal the original.
   task automatic roundTrip(input int g, input int n);
      logic [127:0] pend [$];
      logic [127:0] cur;
      int           sent;
      int           recv;
      int           cycles;
      sent   = 0;
      recv   = 0;
      cycles = 0;
      cur    = randState();
      while (recv < n && cycles < n * 12 + 100) begin
         outReady[g] = 1'($urandom);
         if (sent < n) begin
            inValid[g] = 1'b1;
            dataIn[g]  = refMix(cur, 1'b0);
         end else begin
            inValid[g] = 1'b0;
         end
         if (inValid[g] && inReady[g]) begin
            pend.push_back(cur);
            sent++;
            cur = randState();
         end
         if (outValid[g] && outReady[g]) begin
            if (pend.size() == 0) checkOutput("roundtrip_spurious", dataOut[g], 128'(0) ^ ~dataOut[g]);
            else                  checkOutput("roundtrip", dataOut[g], pend.pop_front());
            recv++;
         end
         @(negedge clk);
         cycles++;
      end
      checkOutput("roundtrip_count", 128'(recv), 128'(n));
      inValid[g]  = 1'b0;
      outReady[g] = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [127:0] d;
      logic [127:0] expected;
      for (int g = 0; g < 3; g++) begin
         inValid[g]  = 1'b0;
         dataIn[g]   = '0;
         outReady[g] = 1'b1;
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #20;
      for (int g = 0; g < 3; g++) begin
         checkOutput("reset_in_ready", 128'(inReady[g]), 128'(1));
         checkOutput("reset_out_valid", 128'(outValid[g]), 128'(0));
         checkOutput("reset_busy", 128'(busy[g]), 128'(0));
         checkOutput("reset_data_out", dataOut[g], 128'(0));
      end
      #10 rst_n = 1'b1;
      @(negedge clk);

      // Known-answer vectors for every width.
      applyStimulus(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      checkOutput("kat_c1", dataOut[0], 128'hdb135345_f20a225c_01010101_c6c6c6c6);
      applyStimulus(1, 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_9fdc589d);
      checkOutput("kat_c2", dataOut[1], 128'h2d26314c_d4d4d4d5_db135345_f20a225c);
      applyStimulus(2, 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_9fdc589d);
      checkOutput("kat_c4", dataOut[2], 128'h2d26314c_d4d4d4d5_db135345_f20a225c);
      @(negedge clk);

      // A few random single blocks per width.
      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < 5; i++) begin
            applyStimulus(g, randState());
            @(negedge clk);
         end
      end

      // Backpressure: result held for 10 cycles, new in_valid ignored.
      d = randState();
      expected = refMix(d, 1'b1);
      outReady[0] = 1'b0;
      applyStimulus(0, d);
      for (int i = 0; i < 10; i++) begin
         inValid[0] = 1'b1;
         dataIn[0]  = ~d;
         @(negedge clk);
         checkOutput("bp_data_hold", dataOut[0], expected);
         checkOutput("bp_in_ready", 128'(inReady[0]), 128'(0));
         checkOutput("bp_out_valid", 128'(outValid[0]), 128'(1));
      end
      outReady[0] = 1'b1;
      inValid[0]  = 1'b0;
      @(negedge clk);
      checkOutput("bp_idle_in_ready", 128'(inReady[0]), 128'(1));
      checkOutput("bp_idle_out_valid", 128'(outValid[0]), 128'(0));
      applyStimulus(0, randState());
      @(negedge clk);

      // Asynchronous reset while instance 0 is at step 2 of a block.
      inValid[0] = 1'b1;
      dataIn[0]  = randState();
      @(negedge clk);
      inValid[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
         checkOutput("midrst_out_valid", 128'(outValid[g]), 128'(0));
         checkOutput("midrst_data_out", dataOut[g], 128'(0));
         checkOutput("midrst_in_ready", 128'(inReady[g]), 128'(1));
         checkOutput("midrst_busy", 128'(busy[g]), 128'(0));
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         applyStimulus(g, randState());
         @(negedge clk);
      end

      // Round trips with back-to-back inputs and random backpressure.
      roundTrip(0, 1000);
      roundTrip(1, 200);
      roundTrip(2, 200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
